line_compositor: RTL and testbench

- Parametrised successor to the PPU pixel sink. Consumes the BG/window and OBJ pixel streams during mode 3.
- Discards the SCX fine-scroll pixels, resolves BG/OBJ priority (DMG or CGB master-priority rule), maps palettes, and writes shades into a ping-pong line buffer.
- The completed line is exposed on a read port for scanout/LCD logic, so a full-frame array is no longer needed.

---
 rtl/ppu_types_pkg.sv | 14 +
 rtl/ppu_util_pkg.sv | 19 +
 rtl/line_buffer_pingpong.sv | 40 ++++
 rtl/line_compositor.sv | 156 +++++++++++++++
 tb/tb_line_compositor.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_types_pkg.sv
// Shared PPU pixel types, screen-geometry defaults and the BG/OBJ priority-rule selector.
package ppu_types_pkg;

  typedef logic [1:0] color_id_t;

  localparam int unsigned GB_SCREEN_WIDTH  = 160;
  localparam int unsigned GB_SCREEN_HEIGHT = 144;

  typedef enum logic {
    PrioDmg,
    PrioCgb
  } prio_rule_e;

endpackage

// File: rtl/ppu_util_pkg.sv
// Palette lookup and BG/OBJ priority resolution shared by the PPU pixel paths.
package ppu_util_pkg;
  import ppu_types_pkg::*;

  function automatic color_id_t palette_map(input logic [7:0] pal, input color_id_t id);
    return pal[{id, 1'b0} +: 2];
  endfunction

  // CGB adds a master override: with LCDC[0] clear the BG never hides objects.
  function automatic logic resolve_priority(input prio_rule_e rule, input logic obj_valid,
                                            input color_id_t objc, input color_id_t bgc,
                                            input logic obj_bg_prio, input logic bg_en);
    logic bg_yields;
    bg_yields = !obj_bg_prio || (bgc == 2'd0);
    if (rule == PrioCgb) bg_yields = bg_yields || !bg_en;
    return obj_valid && (objc != 2'd0) && bg_yields;
  endfunction

endpackage

// File: rtl/line_buffer_pingpong.sv
// Two-bank line store: writes go to wr_bank, the registered read port sees the other bank.
module line_buffer_pingpong #(
  parameter int unsigned Depth  = 160,
  parameter int unsigned ShadeW = 2,
  parameter int unsigned AddrW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AddrW-1:0]  wr_addr,
  input  logic [ShadeW-1:0] wr_data,
  input  logic              toggle,
  input  logic [AddrW-1:0]  rd_addr,
  output logic              wr_bank,
  output logic [ShadeW-1:0] rd_data
);

  logic [ShadeW-1:0] mem_q [2][Depth];
  logic              wr_bank_q;
  logic [ShadeW-1:0] rd_data_q;

  // Storage is deliberately not reset; only the bank pointer and read register are.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < Depth)) mem_q[wr_bank_q][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (toggle) wr_bank_q <= ~wr_bank_q;
      rd_data_q <= (32'(rd_addr) < Depth) ? mem_q[~wr_bank_q][rd_addr] : '0;
    end
  end

  assign wr_bank = wr_bank_q;
  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_compositor.sv
// Mode-3 pixel sink: drops SCX fine-scroll pixels, mixes BG/OBJ, fills a ping-pong line buffer.
// Optional LINE_COMPOSITOR_LAYER_MASK_EN adds dbg_bg_off/dbg_obj_off layer masks.
module line_compositor
  import ppu_types_pkg::*;
  import ppu_util_pkg::*;
#(
  parameter int unsigned SCREEN_W = GB_SCREEN_WIDTH,
  parameter int unsigned SCREEN_H = GB_SCREEN_HEIGHT,
  parameter int unsigned SHADE_W  = 2,
  parameter int unsigned X_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_transfer_en,
  input  logic               start_line,
  input  logic [2:0]         scx_fine,
  input  logic               lcdc_bg_en,
  input  logic               lcdc_obj_en,
  input  logic               cgb_mode,
  input  logic [7:0]         bgp,
  input  logic [7:0]         obp0,
  input  logic [7:0]         obp1,
  input  logic               stall,
`ifdef LINE_COMPOSITOR_LAYER_MASK_EN
  input  logic               dbg_bg_off,
  input  logic               dbg_obj_off,
`endif
  input  logic               bg_valid,
  input  logic [1:0]         bg_color,
  output logic               bg_ready,
  input  logic               obj_valid,
  input  logic [1:0]         obj_color,
  input  logic               obj_pal_sel,
  input  logic               obj_bg_prio,
  output logic               obj_ready,
  output logic [X_W-1:0]     pixel_x,
  input  logic [X_W-1:0]     rd_addr,
  output logic [SHADE_W-1:0] rd_data,
  output logic               line_done,
  output logic               frame_done
);

  localparam int unsigned YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StDiscard,
    StDraw
  } state_e;

  state_e           state_q, state_d;
  logic [X_W-1:0]   pixel_x_q, pixel_x_d;
  logic [2:0]       disc_q, disc_d;
  logic [YW-1:0]    y_q, y_d;
  logic             line_done_q, line_done_d;
  logic             frame_done_q, frame_done_d;
  logic             consume, wr_en, toggle, obj_wins, wr_bank;
  color_id_t        bgc, objc, shade;

  // start_line has priority, so a coincident pixel is left in the FIFO.
  assign consume   = pixel_transfer_en && bg_valid && !stall && (state_q != StIdle) && !start_line;
  assign bg_ready  = consume;
  assign obj_ready = consume && obj_valid;

  always_comb begin
    bgc  = (lcdc_bg_en || cgb_mode) ? bg_color : 2'd0;
    objc = lcdc_obj_en ? obj_color : 2'd0;
`ifdef LINE_COMPOSITOR_LAYER_MASK_EN
    if (dbg_bg_off) bgc = 2'd0;
    if (dbg_obj_off) objc = 2'd0;
`endif
    obj_wins = resolve_priority(cgb_mode ? PrioCgb : PrioDmg, obj_valid, objc, bgc,
                                obj_bg_prio, lcdc_bg_en);
    shade    = obj_wins ? palette_map(obj_pal_sel ? obp1 : obp0, objc) : palette_map(bgp, bgc);
  end

  always_comb begin
    state_d      = state_q;
    pixel_x_d    = pixel_x_q;
    disc_d       = disc_q;
    y_d          = y_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    toggle       = 1'b0;
    if (start_line) begin
      pixel_x_d = '0;
      disc_d    = scx_fine;
      state_d   = (scx_fine != 3'd0) ? StDiscard : StDraw;
    end else if (consume) begin
      unique case (state_q)
        StDiscard: begin
          disc_d = disc_q - 3'd1;
          if (disc_q == 3'd1) state_d = StDraw;
        end
        StDraw: begin
          wr_en = 1'b1;
          if (pixel_x_q == X_W'(SCREEN_W - 1)) begin
            state_d     = StIdle;
            pixel_x_d   = '0;
            toggle      = 1'b1;
            line_done_d = 1'b1;
            if (y_q == YW'(SCREEN_H - 1)) begin
              y_d          = '0;
              frame_done_d = 1'b1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            pixel_x_d = pixel_x_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pixel_x_q    <= '0;
      disc_q       <= '0;
      y_q          <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixel_x_q    <= pixel_x_d;
      disc_q       <= disc_d;
      y_q          <= y_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  line_buffer_pingpong #(
    .Depth (SCREEN_W),
    .ShadeW(SHADE_W),
    .AddrW (X_W)
  ) u_line_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(pixel_x_q),
    .wr_data(SHADE_W'(shade)),
    .toggle (toggle),
    .rd_addr(rd_addr),
    .wr_bank(wr_bank),
    .rd_data(rd_data)
  );

  assign pixel_x    = pixel_x_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_compositor.sv
// Self-checking bench for line_compositor: table vectors, random pixels vs a bank-level model.
module tb_line_compositor;

  localparam int W = 160;
  localparam int H = 144;

  typedef struct {
    logic [1:0] bgc;
    logic       ov;
    logic [1:0] oc;
    logic       sel;
    logic       prio;
    logic       bg_en;
    logic       obj_en;
    logic       cgb;
    logic [7:0] bgp;
    logic [7:0] obp0;
    logic [7:0] obp1;
    logic [1:0] exp;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_transfer_en, start_line, lcdc_bg_en, lcdc_obj_en, cgb_mode, stall;
  logic [2:0] scx_fine;
  logic [7:0] bgp, obp0, obp1;
  logic       bg_valid, bg_ready, obj_valid, obj_pal_sel, obj_bg_prio, obj_ready;
  logic [1:0] bg_color, obj_color, rd_data;
  logic [7:0] pixel_x, rd_addr;
  logic       line_done, frame_done;

  always #5 clk = ~clk;

  line_compositor #(
    .SCREEN_W(W),
    .SCREEN_H(H),
    .SHADE_W (2),
    .X_W     (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_transfer_en(pixel_transfer_en),
    .start_line       (start_line),
    .scx_fine         (scx_fine),
    .lcdc_bg_en       (lcdc_bg_en),
    .lcdc_obj_en      (lcdc_obj_en),
    .cgb_mode         (cgb_mode),
    .bgp              (bgp),
    .obp0             (obp0),
    .obp1             (obp1),
    .stall            (stall),
`ifdef LINE_COMPOSITOR_LAYER_MASK_EN
    .dbg_bg_off       (1'b0),
    .dbg_obj_off      (1'b0),
`endif
    .bg_valid         (bg_valid),
    .bg_color         (bg_color),
    .bg_ready         (bg_ready),
    .obj_valid        (obj_valid),
    .obj_color        (obj_color),
    .obj_pal_sel      (obj_pal_sel),
    .obj_bg_prio      (obj_bg_prio),
    .obj_ready        (obj_ready),
    .pixel_x          (pixel_x),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .line_done        (line_done),
    .frame_done       (frame_done)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         fd_cnt = 0;
  logic [1:0] mem_m [2][W];
  int         mbank = 0;
  int         my = 0;
  pix_t       tbl [11];
  pix_t       line_px [W];

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_shade(input pix_t p);
    int         b, o, id;
    bit         obj;
    logic [7:0] pal;
    b   = (p.bg_en || p.cgb) ? int'(p.bgc) : 0;
    o   = p.obj_en ? int'(p.oc) : 0;
    obj = p.ov && (o != 0) && (!p.prio || b == 0 || (p.cgb && !p.bg_en));
    pal = obj ? (p.sel ? p.obp1 : p.obp0) : p.bgp;
    id  = obj ? o : b;
    return 2'((pal >> (2 * id)) & 8'h3);
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    p.bgc = 2'($urandom); p.ov = 1'($urandom); p.oc = 2'($urandom);
    p.sel = 1'($urandom); p.prio = 1'($urandom); p.bg_en = 1'($urandom);
    p.obj_en = 1'($urandom); p.cgb = 1'($urandom); p.bgp = 8'($urandom);
    p.obp0 = 8'($urandom); p.obp1 = 8'($urandom);
    p.exp = ref_shade(p);
    return p;
  endfunction

  function automatic pix_t flat_pix(input logic [1:0] c);
    pix_t p;
    p = '{c, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE4, 8'h00, 8'h00, 2'd0};
    p.exp = ref_shade(p);
    return p;
  endfunction

  task automatic apply(input pix_t p);
    bg_color = p.bgc; obj_valid = p.ov; obj_color = p.oc; obj_pal_sel = p.sel;
    obj_bg_prio = p.prio; lcdc_bg_en = p.bg_en; lcdc_obj_en = p.obj_en; cgb_mode = p.cgb;
    bgp = p.bgp; obp0 = p.obp0; obp1 = p.obp1;
  endtask

  // Offer one pixel until it is popped; a drawn pixel lands in the model's write bank.
  task automatic push(input pix_t p, input bit draw, input int x, input bit rnd_stall);
    bit popped = 0;
    apply(p);
    bg_valid = 1'b1;
    for (int c = 0; c < 64 && !popped; c++) begin
      stall = rnd_stall && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (stall) chk("stall_blocks_pop", bg_ready, 0);
      popped = bg_ready;
      if (popped) chk("obj_ready", obj_ready, p.ov);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    if (!popped) begin
      n_fail++;
      $display("FAIL pop_timeout: got no pop expected pop at %0t", $time);
      $fatal(1, "no pop within cycle budget");
    end
    if (draw) begin
      mem_m[mbank][x] = p.exp;
      if (x < W - 1) chk("pixel_x", pixel_x, x + 1);
    end
  endtask

  task automatic start(input int scx);
    bg_valid = 1'b0;
    scx_fine = 3'(scx);
    start_line = 1'b1;
    @(posedge clk);
    #1;
    start_line = 1'b0;
    chk("start_px", pixel_x, 0);
  endtask

  task automatic finish_line();
    bg_valid = 1'b0;
    chk("line_done", line_done, 1);
    chk("frame_done", frame_done, (my == H - 1));
    chk("px_wrap", pixel_x, 0);
    mbank ^= 1;
    my = (my == H - 1) ? 0 : my + 1;
    @(posedge clk);
    #1;
    chk("line_done_pulse", line_done, 0);
    chk("frame_done_pulse", frame_done, 0);
  endtask

  task automatic run_line(input int scx, input bit rs);
    start(scx);
    for (int i = 0; i < scx; i++) push(line_px[0], 0, 0, rs);
    chk("disc_px", pixel_x, 0);
    for (int x = 0; x < W; x++) push(line_px[x], 1, x, rs);
    finish_line();
  endtask

  task automatic read_chk(input int addr, input logic [1:0] exp);
    rd_addr = 8'(addr);
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, exp);
  endtask

  task automatic read_line();
    for (int x = 0; x < W; x++) read_chk(x, mem_m[mbank ^ 1][x]);
    read_chk(W, 2'd0);
    read_chk(255, 2'd0);
  endtask

  initial begin
    //          bgc  ov oc  sel prio bg obj cgb bgp    obp0   obp1   exp
    tbl[0]  = '{2'd1, 1, 2'd2, 1, 1, 1, 1, 0, 8'hE4, 8'h00, 8'h90, 2'd1};
    tbl[1]  = '{2'd0, 1, 2'd2, 1, 1, 1, 1, 0, 8'hE4, 8'h00, 8'h90, 2'd1};
    tbl[2]  = '{2'd3, 1, 2'd1, 0, 1, 0, 1, 1, 8'h1B, 8'h0C, 8'h00, 2'd3};
    tbl[3]  = '{2'd3, 1, 2'd1, 0, 1, 0, 1, 0, 8'h1B, 8'h0C, 8'h00, 2'd3};
    tbl[4]  = '{2'd2, 1, 2'd3, 0, 0, 1, 0, 0, 8'hE4, 8'hFF, 8'hFF, 2'd2};
    tbl[5]  = '{2'd1, 0, 2'd3, 0, 0, 1, 1, 0, 8'hE4, 8'hFF, 8'hFF, 2'd1};
    tbl[6]  = '{2'd2, 1, 2'd3, 0, 1, 1, 1, 1, 8'hE4, 8'hFF, 8'hFF, 2'd2};
    tbl[7]  = '{2'd2, 1, 2'd3, 0, 0, 1, 1, 1, 8'hE4, 8'h40, 8'hFF, 2'd1};
    tbl[8]  = '{2'd3, 1, 2'd0, 0, 0, 1, 1, 0, 8'hE4, 8'hFF, 8'hFF, 2'd3};
    tbl[9]  = '{2'd3, 0, 2'd0, 0, 0, 0, 1, 0, 8'h1B, 8'hFF, 8'hFF, 2'd3};
    tbl[10] = '{2'd0, 1, 2'd1, 0, 0, 1, 1, 0, 8'hE4, 8'h0C, 8'hFF, 2'd3};

    reset = 1'b1; pixel_transfer_en = 1'b1; start_line = 1'b0; scx_fine = 3'd0;
    stall = 1'b0; rd_addr = 8'd0; bg_valid = 1'b1;
    apply(flat_pix(2'd1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixel_x", pixel_x, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_bg_ready", bg_ready, 0);
    chk("rst_obj_ready", obj_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_no_pop", bg_ready, 0);
    @(posedge clk);
    #1;

    // 3 fine-scroll pixels dropped, then 160 shades of 1.
    for (int x = 0; x < W; x++) line_px[x] = flat_pix(2'd1);
    run_line(3, 0);
    bg_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_hold_pop", bg_ready, 0);
      @(posedge clk);
      #1;
    end
    bg_valid = 1'b0;
    read_chk(0, 2'd1);
    read_chk(W - 1, 2'd1);

    // Priority/palette table at the head of a line, random pixels with stalls after it.
    for (int x = 0; x < W; x++) line_px[x] = (x < 11) ? tbl[x] : rand_pix();
    run_line(0, 1);
    read_line();

    // Stall mid-line, then start_line colliding with a pop.
    start(0);
    for (int x = 0; x < 40; x++) push(rand_pix(), 1, x, 0);
    chk("pre_stall_px", pixel_x, 40);
    stall = 1'b1;
    bg_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_bg_ready", bg_ready, 0);
      chk("stall_obj_ready", obj_ready, 0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    chk("stall_px_hold", pixel_x, 40);
    for (int x = 40; x < 50; x++) push(rand_pix(), 1, x, 0);
    apply(rand_pix());
    obj_valid = 1'b1;
    scx_fine = 3'd0;
    start_line = 1'b1;
    @(negedge clk);
    chk("coinc_bg_ready", bg_ready, 0);
    chk("coinc_obj_ready", obj_ready, 0);
    @(posedge clk);
    #1;
    start_line = 1'b0;
    chk("coinc_px", pixel_x, 0);
    for (int x = 0; x < W; x++) push(rand_pix(), 1, x, 1);
    finish_line();
    read_line();

    // Run past a frame boundary; each line a distinct flat colour to expose the bank swap.
    begin
      int fd_base;
      fd_base = fd_cnt;
      for (int l = 0; l <= H; l++) begin
        for (int x = 0; x < W; x++) line_px[x] = flat_pix(2'(l));
        run_line(int'($urandom_range(0, 7)), 0);
        read_chk(0, 2'(l));
        read_chk(W - 1, 2'(l));
      end
      chk("frame_done_count", fd_cnt - fd_base, 1);
    end

    // Asynchronous reset at pixel_x == 80.
    start(0);
    for (int x = 0; x < 80; x++) push(rand_pix(), 1, x, 0);
    chk("pre_rst_px", pixel_x, 80);
    bg_valid = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_pixel_x", pixel_x, 0);
    chk("arst_line_done", line_done, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_bg_ready", bg_ready, 0);
    mbank = 0;
    my = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bg_valid = 1'b0;
    read_chk(100, mem_m[1][100]);
    read_chk(0, mem_m[1][0]);
    for (int x = 0; x < W; x++) line_px[x] = rand_pix();
    run_line(int'($urandom_range(0, 7)), 1);
    read_line();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
